// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake and error flags.
module shift_sub_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH:0]    a;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  d;
    logic [CW-1:0]     count;
    logic              err_dz;
    logic              err_ov;

    logic [WIDTH+1:0]  a_sh;
    logic [WIDTH+1:0]  diff;
    logic              borrow;

    // Shifted partial remainder and trial subtraction; extra top bit exposes the borrow
    always_comb begin
        a_sh   = {a, q[WIDTH-1]};
        diff   = a_sh - {2'b00, d};
        borrow = diff[WIDTH+1];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            err_dz      <= 1'b0;
            err_ov      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        d      <= divisor;
                        a      <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        q      <= dividend[WIDTH-1:0];
                        err_dz <= 1'b0;
                        err_ov <= 1'b0;
                        busy   <= 1'b1;
                        if (divisor == '0) begin
                            err_dz <= 1'b1;
                            state  <= DONE;
                        end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            // Quotient would need more than WIDTH bits
                            err_ov <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q     <= {q[WIDTH-2:0], ~borrow};
                    a     <= borrow ? a_sh[WIDTH:0] : diff[WIDTH:0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= err_dz;
                    overflow    <= err_ov;
                    if (err_dz || err_ov) begin
                        quotient  <= '1;
                        remainder <= '0;
                    end else begin
                        quotient  <= q;
                        remainder <= a[WIDTH-1:0];
                    end
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed cases, handshake, reset abort
// and random operands against an arithmetic reference model.
module tb_shift_sub_divider;

    localparam int unsigned WIDTH = 8;

    logic                Clk;
    logic                Reset_n;
    logic                start;
    logic [2*WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]    divisor;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    quotient;
    logic [WIDTH-1:0]    remainder;
    logic                div_by_zero;
    logic                overflow;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sub_divider #(.WIDTH(WIDTH)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one division, compare against plain arithmetic, optionally check done drops
    task automatic do_div(input logic [15:0] dvd, input logic [7:0] dvs, input bit check_drop);
        int  lat;
        int  nbusy;
        bit  err;
        logic [7:0]  exp_q;
        logic [7:0]  exp_r;
        logic [31:0] recon;
        err = (dvs == 8'd0) || (dvd[15:8] >= dvs);
        if (err) begin
            exp_q = 8'hFF;
            exp_r = 8'h00;
        end else begin
            exp_q = 8'(dvd / dvs);
            exp_r = 8'(dvd % dvs);
        end
        @(negedge Clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge Clk);
        #1 start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(posedge Clk);
            #1;
            lat++;
        end
        check("latency",     32'(lat),         err ? 32'd1 : 32'd9);
        check("busy_cycles", 32'(nbusy),       err ? 32'd1 : 32'd9);
        check("busy_at_done", 32'(busy),       32'd0);
        check("quotient",    32'(quotient),    32'(exp_q));
        check("remainder",   32'(remainder),   32'(exp_r));
        check("div_by_zero", 32'(div_by_zero), 32'(dvs == 8'd0));
        check("overflow",    32'(overflow),    32'(dvs != 8'd0 && dvd[15:8] >= dvs));
        if (!err) begin
            recon = 32'(quotient) * 32'(dvs) + 32'(remainder);
            check("invariant_sum", recon, 32'(dvd));
            check("invariant_rem_lt", 32'(remainder < dvs), 32'd1);
        end
        if (check_drop) begin
            @(posedge Clk);
            #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("result_held", 32'(quotient), 32'(exp_q));
        end
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        logic [7:0] rdvs;
        logic [7:0] rhi;
        logic [7:0] rlo;

        Reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_quot",  32'(quotient),    32'd0);
        check("rst_rem",   32'(remainder),   32'd0);
        check("rst_dz",    32'(div_by_zero), 32'd0);
        check("rst_ov",    32'(overflow),    32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed cases: basic, max legal, zero, divide-by-zero, overflow
        do_div(16'h0064, 8'h07, 1'b1);
        check("basic_q", 32'(quotient), 32'h0E);
        do_div(16'hFEFF, 8'hFF, 1'b1);
        check("max_r", 32'(remainder), 32'hFE);
        do_div(16'h0000, 8'h01, 1'b1);
        do_div(16'h1234, 8'h00, 1'b1);
        do_div(16'h0700, 8'h07, 1'b1);
        do_div(16'h06FF, 8'h07, 1'b1);

        // Start pulse during CALC must be ignored
        @(negedge Clk);
        start    = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (4) @(posedge Clk);
        #1 start = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h55;
        @(posedge Clk);
        #1 start = 1'b0;
        lat = 5;
        while (!done && lat < 20) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check("ign_latency", 32'(lat),       32'd9);
        check("ign_quot",    32'(quotient),  32'h0E);
        check("ign_rem",     32'(remainder), 32'h02);
        @(posedge Clk);
        #1;
        check("ign_no_restart", 32'(busy), 32'd0);

        // Back-to-back: second start lands in the done cycle
        do_div(16'h2710, 8'h64, 1'b0);
        do_div(16'h00FF, 8'h10, 1'b1);

        // Asynchronous reset mid-calculation
        @(negedge Clk);
        start    = 1'b1;
        dividend = 16'h3039;
        divisor  = 8'hC8;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (5) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy),        32'd0);
        check("abort_done", 32'(done),        32'd0);
        check("abort_quot", 32'(quotient),    32'd0);
        check("abort_rem",  32'(remainder),   32'd0);
        check("abort_dz",   32'(div_by_zero), 32'd0);
        check("abort_ov",   32'(overflow),    32'd0);
        @(negedge Clk);
        Reset_n  = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge Clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        do_div(16'h3039, 8'hC8, 1'b1);

        // Random legal operands
        for (int i = 0; i < 1000; i++) begin
            rdvs = 8'($urandom_range(1, 255));
            rhi  = 8'($urandom_range(0, 32'(rdvs) - 1));
            rlo  = 8'($urandom_range(0, 255));
            do_div({rhi, rlo}, rdvs, (i % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
